// File: rtl/matmul_sequencer_if.sv
// Control and ROM-addressing bundle between a matmul datapath controller (master)
// and the matmul_sequencer (slave).
interface matmul_sequencer_if;
  logic        start;
  logic        hold;
  logic        busy;
  logic        done;
  logic [11:0] rom_a_addr;
  logic [5:0]  rom_b_addr;
  logic        addr_valid;
  logic        acc_en;
  logic        acc_first;
  logic        row_valid;
  logic [5:0]  row_index;
  logic [15:0] cycle_count;

  modport master (
    output start, hold,
    input  busy, done, rom_a_addr, rom_b_addr, addr_valid,
    input  acc_en, acc_first, row_valid, row_index, cycle_count
  );

  modport slave (
    input  start, hold,
    output busy, done, rom_a_addr, rom_b_addr, addr_valid,
    output acc_en, acc_first, row_valid, row_index, cycle_count
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Beat sequencer for a ROWS x N matrix-vector product: issues ROM addresses and
// ROM_LAT-aligned accumulator controls. MATMUL_SEQ_CYCLE_COUNT_EN enables cycle_count.
module matmul_sequencer #(
  parameter int ROWS    = 64,
  parameter int N       = 64,
  parameter int LANES   = 8,
  parameter int ROM_LAT = 2
) (
  input logic              clock,
  input logic              reset_l,
  matmul_sequencer_if.slave bus
);
  localparam int BEATS  = N / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]        state;
  logic [BEAT_W-1:0] beat;
  logic [ROW_W-1:0]  row;
  logic [11:0]       a_addr;

  logic [ROM_LAT-1:0] vld_p, first_p, last_p, final_p;
  logic [ROW_W-1:0]   row_p [ROM_LAT];

  logic              row_vld;
  logic              row_final;
  logic [ROW_W-1:0]  row_idx;

  logic issue, beat_end, run_end;

  assign issue    = (state == ISSUE);
  assign beat_end = (beat == LAST_BEAT);
  assign run_end  = beat_end && (row == LAST_ROW);

  // Everything, including the ROM-latency delay line, freezes as one while hold is high.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      beat      <= '0;
      row       <= '0;
      a_addr    <= '0;
      vld_p     <= '0;
      first_p   <= '0;
      last_p    <= '0;
      final_p   <= '0;
      for (int i = 0; i < ROM_LAT; i++) row_p[i] <= '0;
      row_vld   <= 1'b0;
      row_final <= 1'b0;
      row_idx   <= '0;
    end else if (!bus.hold) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ISSUE;
            beat   <= '0;
            row    <= '0;
            a_addr <= '0;
          end
        end
        ISSUE: begin
          // rom_a_addr = row*BEATS + beat is simply a linear beat count
          a_addr <= a_addr + 12'd1;
          if (beat_end) begin
            beat <= '0;
            row  <= row + ROW_W'(1);
          end else begin
            beat <= beat + BEAT_W'(1);
          end
          if (run_end) state <= DRAIN;
        end
        DRAIN: begin
          if (row_vld && row_final) state <= FIN;
        end
        default: state <= IDLE;
      endcase

      // stage p0: tags captured alongside the address beat
      vld_p[0]   <= issue;
      first_p[0] <= issue && (beat == '0);
      last_p[0]  <= issue && beat_end;
      final_p[0] <= issue && run_end;
      row_p[0]   <= row;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
        last_p[i]  <= last_p[i-1];
        final_p[i] <= final_p[i-1];
        row_p[i]   <= row_p[i-1];
      end

      // stage after the ROM data: the last add of a row has just landed
      row_vld   <= vld_p[ROM_LAT-1] && last_p[ROM_LAT-1];
      row_final <= vld_p[ROM_LAT-1] && final_p[ROM_LAT-1];
      if (vld_p[ROM_LAT-1] && last_p[ROM_LAT-1]) row_idx <= row_p[ROM_LAT-1];
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == FIN) && !bus.hold;
  assign bus.addr_valid = issue && !bus.hold;
  assign bus.rom_a_addr = a_addr;
  assign bus.rom_b_addr = 6'(beat);
  assign bus.acc_en     = vld_p[ROM_LAT-1] && !bus.hold;
  assign bus.acc_first  = vld_p[ROM_LAT-1] && first_p[ROM_LAT-1] && !bus.hold;
  assign bus.row_valid  = row_vld && !bus.hold;
  assign bus.row_index  = 6'(row_idx);

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
  logic [15:0] cyc_cnt;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      cyc_cnt <= '0;
    end else if (!bus.hold) begin
      if (state == IDLE) begin
        if (bus.start) cyc_cnt <= '0;
      end else if (cyc_cnt != 16'hFFFF) begin
        cyc_cnt <= cyc_cnt + 16'd1;
      end
    end
  end

  assign bus.cycle_count = cyc_cnt;
`else
  assign bus.cycle_count = '0;
`endif

endmodule
